// File: rtl/csr_rmw_arbiter_if.sv
// Requester, response and register-file signals of the CSR read-modify-write arbiter.
// slave = arbiter side; master = requesters together with the register file.
interface csr_rmw_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 12
);
  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS-1:0]        req_ready;
  logic [2*NUM_PORTS-1:0]      req_op;
  logic [ADDR_W*NUM_PORTS-1:0] req_addr;
  logic [XLEN*NUM_PORTS-1:0]   req_wdata;
  logic [NUM_PORTS-1:0]        rsp_valid;
  logic [XLEN-1:0]             rsp_rdata;
  logic                        rsp_err;
  logic                        rf_rd_valid;
  logic [ADDR_W-1:0]           rf_rd_addr;
  logic [XLEN-1:0]             rf_rd_data;
  logic                        rf_wr_valid;
  logic [ADDR_W-1:0]           rf_wr_addr;
  logic [XLEN-1:0]             rf_wr_data;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, rf_rd_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           rf_rd_valid, rf_rd_addr, rf_wr_valid, rf_wr_addr, rf_wr_data
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, rf_rd_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           rf_rd_valid, rf_rd_addr, rf_wr_valid, rf_wr_addr, rf_wr_data
  );
endinterface

// File: rtl/csr_rmw_arbiter.sv
// Arbitrates NUM_PORTS requesters onto one CSR read/write port as atomic RMW ops; rsp at accept+RF_LAT+2.
// One op in flight: req_ready only in IDLE, next accept at accept+RF_LAT+3.
// CSR_ARB_FIXED_PRIO_EN: fixed priority (port 0 highest) instead of round-robin.
module csr_rmw_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 12,
  parameter int RF_LAT    = 1
) (
  input logic              clk,
  input logic              rst_n,
  csr_rmw_arbiter_if.slave bus
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = (RF_LAT > 1) ? $clog2(RF_LAT) : 1;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, WAIT, WB} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     port_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   old_q;
  logic [CW-1:0]     cnt;

  logic              grant_vld;
  logic [PW-1:0]     grant_idx;
  logic [1:0]        g_op;
  logic [ADDR_W-1:0] g_addr;
  logic [XLEN-1:0]   g_wdata;
  logic              hs;
  logic              read_only;
  logic              mask_zero;
  logic              ro_err;
  logic              do_write;
  logic [XLEN-1:0]   new_val;

`ifndef CSR_ARB_FIXED_PRIO_EN
  logic [PW-1:0]     rr_ptr;
`endif

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
`ifdef CSR_ARB_FIXED_PRIO_EN
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        grant_vld = 1'b1;
        grant_idx = PW'(i);
      end
    end
`else
    // Scan from the far end so the nearest valid port at/after rr_ptr wins.
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (bus.req_valid[PW'((int'(rr_ptr) + k) % NUM_PORTS)]) begin
        grant_vld = 1'b1;
        grant_idx = PW'((int'(rr_ptr) + k) % NUM_PORTS);
      end
    end
`endif
  end

  // Only the granted port's payload is ever looked at.
  always_comb begin
    g_op    = '0;
    g_addr  = '0;
    g_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_idx == PW'(i)) begin
        g_op    = bus.req_op[2*i +: 2];
        g_addr  = bus.req_addr[ADDR_W*i +: ADDR_W];
        g_wdata = bus.req_wdata[XLEN*i +: XLEN];
      end
    end
  end

  assign hs        = (state == IDLE) && grant_vld && rst_n;
  assign read_only = (addr_q[ADDR_W-1 -: 2] == 2'b11);
  assign mask_zero = (wdata_q == '0);

  always_comb begin
    new_val  = wdata_q;
    ro_err   = 1'b0;
    do_write = 1'b0;
    case (op_q)
      OP_READ:  new_val = old_q;
      OP_WRITE: new_val = wdata_q;
      OP_SET:   new_val = old_q | wdata_q;
      default:  new_val = old_q & ~wdata_q;
    endcase
    if (op_q == OP_WRITE || (op_q != OP_READ && !mask_zero)) begin
      ro_err   = read_only;
      do_write = !read_only;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.req_ready   = '0;
    bus.rsp_valid   = '0;
    bus.rsp_rdata   = '0;
    bus.rsp_err     = 1'b0;
    bus.rf_rd_valid = 1'b0;
    bus.rf_rd_addr  = '0;
    bus.rf_wr_valid = 1'b0;
    bus.rf_wr_addr  = '0;
    bus.rf_wr_data  = '0;
    case (state)
      IDLE: begin
        if (hs) begin
          bus.req_ready[grant_idx] = 1'b1;
          state_nxt = RD;
        end
      end
      RD: begin
        bus.rf_rd_valid = 1'b1;
        bus.rf_rd_addr  = addr_q;
        state_nxt       = WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_nxt = WB;
      end
      default: begin
        bus.rsp_valid[port_q] = 1'b1;
        bus.rsp_rdata         = old_q;
        bus.rsp_err           = ro_err;
        if (do_write) begin
          bus.rf_wr_valid = 1'b1;
          bus.rf_wr_addr  = addr_q;
          bus.rf_wr_data  = new_val;
        end
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_q  <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      cnt     <= '0;
    end else begin
      if (hs) begin
        port_q  <= grant_idx;
        op_q    <= g_op;
        addr_q  <= g_addr;
        wdata_q <= g_wdata;
      end
      if (state == RD) cnt <= CW'(RF_LAT - 1);
      if (state == WAIT) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        else           old_q <= bus.rf_rd_data;
      end
    end
  end

`ifndef CSR_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rr_ptr <= '0;
    else if (hs) rr_ptr <= (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
  end
`endif

endmodule

// File: tb/tb_csr_rmw_arbiter.sv
// Randomised and directed bench for csr_rmw_arbiter against a spec-level CSR/arbitration model.
module tb_csr_rmw_arbiter;
  localparam int NUM_PORTS = 3;
  localparam int XLEN      = 32;
  localparam int ADDR_W    = 12;
  localparam int RF_LAT    = 2;
  localparam int OP_LAT    = RF_LAT + 3;
  localparam int OUT_W     = 2*NUM_PORTS + 2*XLEN + 2*ADDR_W + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csr_rmw_arbiter_if #(.NUM_PORTS(NUM_PORTS), .XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  csr_rmw_arbiter #(.NUM_PORTS(NUM_PORTS), .XLEN(XLEN), .ADDR_W(ADDR_W), .RF_LAT(RF_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [OUT_W-1:0] all_out;
  assign all_out = {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rf_rd_valid,
                    bus.rf_rd_addr, bus.rf_wr_valid, bus.rf_wr_addr, bus.rf_wr_data};

  // Register-file model: fixed read latency, random data on the bus when no read is due.
  logic [XLEN-1:0]   mem [0:4095];
  logic [XLEN-1:0]   ref_mem [0:4095];
  logic [ADDR_W-1:0] pipe_addr [RF_LAT];
  logic              pipe_vld [RF_LAT];
  logic [XLEN-1:0]   junk;
  logic              bd_en = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [XLEN-1:0]   bd_data = '0;

  always @(posedge clk) begin
    pipe_vld[0]  <= bus.rf_rd_valid;
    pipe_addr[0] <= bus.rf_rd_addr;
    for (int i = 1; i < RF_LAT; i++) begin
      pipe_vld[i]  <= pipe_vld[i-1];
      pipe_addr[i] <= pipe_addr[i-1];
    end
    junk <= $urandom;
    if (bus.rf_wr_valid) mem[bus.rf_wr_addr] <= bus.rf_wr_data;
    if (bd_en) mem[bd_addr] <= bd_data;
  end
  assign bus.rf_rd_data = pipe_vld[RF_LAT-1] ? mem[pipe_addr[RF_LAT-1]] : junk;

  logic [ADDR_W-1:0] pool [8] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'hF14, 12'hF11, 12'hC00};
  int ptr_m = 0;

  int                obs_wait, obs_rd_n, obs_rd_at, obs_rsp_n, obs_rsp_at, obs_wr_n, obs_wr_at, obs_spur;
  logic [NUM_PORTS-1:0] obs_ready, obs_rsp_vec;
  logic [ADDR_W-1:0] obs_rd_addr, obs_wr_addr;
  logic [XLEN-1:0]   obs_rdata, obs_wr_data;
  logic              obs_err;

  // CSR semantics: returns old value, error, whether a write happens, and the new value.
  function automatic void model(input logic [1:0] op, input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] wd,
                                output logic [XLEN-1:0] old_v, output logic err, output logic wr,
                                output logic [XLEN-1:0] new_v);
    logic ro;
    ro    = (a[11:10] == 2'b11);
    old_v = ref_mem[a];
    new_v = old_v;
    err   = 1'b0;
    wr    = 1'b0;
    if (op == 2'b01) begin
      new_v = wd; err = ro; wr = !ro;
    end else if (op != 2'b00 && wd != '0) begin
      new_v = (op == 2'b10) ? (old_v | wd) : (old_v & ~wd);
      err = ro; wr = !ro;
    end
    if (wr) ref_mem[a] = new_v;
  endfunction

  function automatic int exp_grant(input logic [NUM_PORTS-1:0] v);
`ifdef CSR_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_PORTS; i++) if (v[i]) return i;
`else
    for (int k = 0; k < NUM_PORTS; k++) if (v[(ptr_m + k) % NUM_PORTS]) return (ptr_m + k) % NUM_PORTS;
`endif
    return -1;
  endfunction

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
    @(negedge clk);
    bd_en = 1'b1; bd_addr = a; bd_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    bd_en = 1'b0;
  endtask

  // Issues one op from a single port and records everything the DUT does until it is idle again.
  task automatic do_op(input int port, input logic [1:0] op, input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] wd);
    bus.req_op[2*port +: 2]         = op;
    bus.req_addr[ADDR_W*port +: ADDR_W] = a;
    bus.req_wdata[XLEN*port +: XLEN] = wd;
    bus.req_valid[port] = 1'b1;
    obs_wait = 0;
    #1;
    while (!bus.req_ready[port] && obs_wait < 40) begin
      @(negedge clk); #1; obs_wait++;
    end
    obs_ready = bus.req_ready;
    ptr_m = (port + 1) % NUM_PORTS;
    obs_rd_n = 0; obs_rd_at = -1; obs_rsp_n = 0; obs_rsp_at = -1; obs_wr_n = 0; obs_wr_at = -1; obs_spur = 0;
    obs_rd_addr = '0; obs_wr_addr = '0; obs_rdata = '0; obs_wr_data = '0; obs_err = 1'b0; obs_rsp_vec = '0;
    @(negedge clk);
    bus.req_valid[port] = 1'b0;
    bus.req_op    = (2*NUM_PORTS)'($urandom);
    bus.req_addr  = {$urandom, $urandom};
    bus.req_wdata = {$urandom, $urandom, $urandom};
    for (int n = 1; n <= OP_LAT; n++) begin
      #1;
      if (bus.rf_rd_valid) begin obs_rd_n++; obs_rd_at = n; obs_rd_addr = bus.rf_rd_addr; end
      if (bus.rsp_valid != '0) begin
        obs_rsp_n++; obs_rsp_at = n; obs_rsp_vec = bus.rsp_valid; obs_rdata = bus.rsp_rdata; obs_err = bus.rsp_err;
      end
      if (bus.rf_wr_valid) begin obs_wr_n++; obs_wr_at = n; obs_wr_addr = bus.rf_wr_addr; obs_wr_data = bus.rf_wr_data; end
      if (!bus.rf_wr_valid && (bus.rf_wr_addr != '0 || bus.rf_wr_data != '0)) obs_spur++;
      if (bus.rsp_valid == '0 && (bus.rsp_rdata != '0 || bus.rsp_err)) obs_spur++;
      if (n < OP_LAT) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.req_valid = '0; bus.req_op = '0; bus.req_addr = '0; bus.req_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (all_out !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", all_out); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (all_out !== '0) begin errors++; $display("FAIL idle_outputs got %h want 0", all_out); end
  endtask

  task automatic test_read();
    logic [XLEN-1:0] e_old, e_new; logic e_err, e_wr;
    poke(12'h300, 32'h0000_1808);
    model(2'b00, 12'h300, 32'h0, e_old, e_err, e_wr, e_new);
    do_op(0, 2'b00, 12'h300, 32'h0);
    checks++; if (obs_rd_n !== 1 || obs_rd_at !== 1 || obs_rd_addr !== 12'h300)
      begin errors++; $display("FAIL read_rf_rd n=%0d at=%0d addr=%h want 1,1,300", obs_rd_n, obs_rd_at, obs_rd_addr); end
    checks++; if (obs_rsp_n !== 1 || obs_rsp_at !== RF_LAT + 2 || obs_rsp_vec !== 3'b001)
      begin errors++; $display("FAIL read_rsp n=%0d at=%0d vec=%b want 1,%0d,001", obs_rsp_n, obs_rsp_at, obs_rsp_vec, RF_LAT + 2); end
    checks++; if (obs_rdata !== 32'h0000_1808 || obs_err !== 1'b0 || obs_wr_n !== 0)
      begin errors++; $display("FAIL read_data rdata=%h err=%b wr=%0d want 00001808,0,0", obs_rdata, obs_err, obs_wr_n); end
  endtask

  task automatic test_set();
    logic [XLEN-1:0] e_old, e_new; logic e_err, e_wr;
    poke(12'h304, 32'h0000_0008);
    model(2'b10, 12'h304, 32'h80, e_old, e_err, e_wr, e_new);
    do_op(1, 2'b10, 12'h304, 32'h0000_0080);
    checks++; if (obs_ready !== 3'b010 || obs_rsp_vec !== 3'b010 || obs_rsp_at !== RF_LAT + 2)
      begin errors++; $display("FAIL set_port ready=%b rsp=%b at=%0d want 010,010,%0d", obs_ready, obs_rsp_vec, obs_rsp_at, RF_LAT + 2); end
    checks++; if (obs_rdata !== 32'h0000_0008 || obs_err !== 1'b0)
      begin errors++; $display("FAIL set_rdata got %h err %b want 00000008,0", obs_rdata, obs_err); end
    checks++; if (obs_wr_n !== 1 || obs_wr_at !== RF_LAT + 2 || obs_wr_addr !== 12'h304 || obs_wr_data !== 32'h0000_0088)
      begin errors++; $display("FAIL set_write n=%0d at=%0d addr=%h data=%h want 1,%0d,304,00000088", obs_wr_n, obs_wr_at, obs_wr_addr, obs_wr_data, RF_LAT + 2); end
    checks++; if (mem[12'h304] !== 32'h0000_0088)
      begin errors++; $display("FAIL set_rf_content got %h want 00000088", mem[12'h304]); end
  endtask

  task automatic test_exceptions();
    logic [XLEN-1:0] e_old, e_new; logic e_err, e_wr;
    poke(12'hF14, 32'hA5A5_0003);
    poke(12'hC00, 32'h0000_1234);
    model(2'b11, 12'h300, 32'h0, e_old, e_err, e_wr, e_new);
    do_op(0, 2'b11, 12'h300, 32'h0);
    checks++; if (obs_wr_n !== 0 || obs_err !== 1'b0 || obs_rdata !== 32'h0000_1808 || obs_rsp_n !== 1)
      begin errors++; $display("FAIL clear_zero wr=%0d err=%b rdata=%h want 0,0,00001808", obs_wr_n, obs_err, obs_rdata); end
    model(2'b01, 12'hF14, 32'h5, e_old, e_err, e_wr, e_new);
    do_op(2, 2'b01, 12'hF14, 32'h0000_0005);
    checks++; if (obs_wr_n !== 0 || obs_err !== 1'b1 || obs_rdata !== 32'hA5A5_0003 || obs_rsp_vec !== 3'b100)
      begin errors++; $display("FAIL ro_write wr=%0d err=%b rdata=%h vec=%b want 0,1,a5a50003,100", obs_wr_n, obs_err, obs_rdata, obs_rsp_vec); end
    model(2'b10, 12'hC00, 32'h0, e_old, e_err, e_wr, e_new);
    do_op(1, 2'b10, 12'hC00, 32'h0);
    checks++; if (obs_wr_n !== 0 || obs_err !== 1'b0 || obs_rdata !== 32'h0000_1234)
      begin errors++; $display("FAIL ro_set_zero wr=%0d err=%b rdata=%h want 0,0,00001234", obs_wr_n, obs_err, obs_rdata); end
    model(2'b11, 12'hC00, 32'h4, e_old, e_err, e_wr, e_new);
    do_op(1, 2'b11, 12'hC00, 32'h4);
    checks++; if (obs_wr_n !== 0 || obs_err !== 1'b1 || obs_rdata !== 32'h0000_1234)
      begin errors++; $display("FAIL ro_clear wr=%0d err=%b rdata=%h want 0,1,00001234", obs_wr_n, obs_err, obs_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] e_old, e_new; logic e_err, e_wr;
    logic [1:0] ops [6] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b11};
    logic [XLEN-1:0] wd;
    poke(12'h305, $urandom);
    for (int i = 0; i < 6; i++) begin
      wd = (i == 5) ? '0 : $urandom;
      model(ops[i], 12'h305, wd, e_old, e_err, e_wr, e_new);
      do_op(2, ops[i], 12'h305, wd);
      if (i > 0) begin
        checks++; if (obs_wait !== 0) begin errors++; $display("FAIL b2b_accept op%0d waited %0d want 0", i, obs_wait); end
      end
      checks++; if (obs_rdata !== e_old || obs_wr_n !== int'(e_wr) || (e_wr && obs_wr_data !== e_new))
        begin errors++; $display("FAIL b2b_rmw op%0d rdata=%h wr=%0d data=%h want %h,%0d,%h", i, obs_rdata, obs_wr_n, obs_wr_data, e_old, e_wr, e_new); end
    end
    checks++; if (mem[12'h305] !== ref_mem[12'h305])
      begin errors++; $display("FAIL b2b_final got %h want %h", mem[12'h305], ref_mem[12'h305]); end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] e_old, e_new, wd; logic e_err, e_wr;
    logic [1:0] op; logic [ADDR_W-1:0] a; int p; int bad;
    for (int i = 0; i < 8; i++) poke(pool[i], $urandom);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      p  = $urandom_range(0, NUM_PORTS - 1);
      op = 2'($urandom);
      a  = pool[$urandom_range(0, 7)];
      wd = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      model(op, a, wd, e_old, e_err, e_wr, e_new);
      do_op(p, op, a, wd);
      checks++;
      if (obs_ready !== NUM_PORTS'(1 << p) || obs_rd_n !== 1 || obs_rd_at !== 1 || obs_rd_addr !== a ||
          obs_rsp_n !== 1 || obs_rsp_at !== RF_LAT + 2 || obs_rsp_vec !== NUM_PORTS'(1 << p) ||
          obs_rdata !== e_old || obs_err !== e_err || obs_wr_n !== int'(e_wr) || obs_spur !== 0 ||
          (e_wr && (obs_wr_at !== RF_LAT + 2 || obs_wr_addr !== a || obs_wr_data !== e_new))) begin
        errors++; bad++;
        $display("FAIL random_op%0d p=%0d op=%0d a=%h got rdy=%b rsp=%b@%0d rdata=%h err=%b wr=%0d:%h=%h spur=%0d want rdata=%h err=%b wr=%0d data=%h",
                 i, p, op, a, obs_ready, obs_rsp_vec, obs_rsp_at, obs_rdata, obs_err, obs_wr_n, obs_wr_addr, obs_wr_data,
                 obs_spur, e_old, e_err, e_wr, e_new);
      end
    end
  endtask

  task automatic test_contention(input logic [NUM_PORTS-1:0] vmask, input int ngrant);
    int got, last, budget, g;
    got = 0; last = -1; budget = 0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      bus.req_op[2*p +: 2] = 2'b00;
      bus.req_addr[ADDR_W*p +: ADDR_W] = pool[p];
      bus.req_wdata[XLEN*p +: XLEN] = '0;
    end
    bus.req_valid = vmask;
    #1;
    while (got < ngrant && budget < 20 * ngrant) begin
      if (bus.req_ready != '0) begin
        g = exp_grant(vmask);
        checks++; if (bus.req_ready !== NUM_PORTS'(1 << g))
          begin errors++; $display("FAIL contention_grant%0d got %b want port %0d", got, bus.req_ready, g); end
        if (last >= 0) begin
          checks++; if (cyc - last !== OP_LAT)
            begin errors++; $display("FAIL contention_spacing got %0d want %0d", cyc - last, OP_LAT); end
        end
        last = cyc; ptr_m = (g + 1) % NUM_PORTS; got++;
      end
      @(negedge clk); #1; budget++;
    end
    bus.req_valid = '0;
    checks++; if (got !== ngrant) begin errors++; $display("FAIL contention_count got %0d want %0d", got, ngrant); end
    repeat (OP_LAT) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [XLEN-1:0] e_old, e_new; logic e_err, e_wr; int w; int seen;
    poke(12'h341, 32'h1234_5678);
    bus.req_op[2 +: 2] = 2'b01; bus.req_addr[ADDR_W +: ADDR_W] = 12'h341; bus.req_wdata[XLEN +: XLEN] = 32'hDEAD_BEEF;
    bus.req_valid[1] = 1'b1;
    w = 0; #1;
    while (!bus.req_ready[1] && w < 40) begin @(negedge clk); #1; w++; end
    @(negedge clk); bus.req_valid[1] = 1'b0;
    @(negedge clk);
    bus.req_valid[2] = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++; if (all_out !== '0) begin errors++; $display("FAIL reset_in_wait got %h want 0", all_out); end
    repeat (2) @(negedge clk);
    bus.req_valid = '0;
    rst_n = 1'b1;
    ptr_m = 0;
    seen = 0;
    for (int n = 0; n < OP_LAT + 2; n++) begin
      @(negedge clk); #1;
      if (bus.rsp_valid != '0 || bus.rf_wr_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL reset_no_tail got %0d cycles with rsp/wr want 0", seen); end
    checks++; if (mem[12'h341] !== 32'h1234_5678)
      begin errors++; $display("FAIL reset_no_write got %h want 12345678", mem[12'h341]); end
    test_contention(3'b110, 1);
    model(2'b10, 12'h341, 32'h0000_0081, e_old, e_err, e_wr, e_new);
    do_op(1, 2'b10, 12'h341, 32'h0000_0081);
    checks++; if (obs_rdata !== 32'h1234_5678 || obs_wr_n !== 1 || obs_wr_data !== 32'h1234_56F9 || obs_rsp_vec !== 3'b010)
      begin errors++; $display("FAIL reset_fresh rdata=%h wr=%0d data=%h vec=%b want 12345678,1,123456f9,010", obs_rdata, obs_wr_n, obs_wr_data, obs_rsp_vec); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_set();
    test_exceptions();
    test_back_to_back();
    test_random();
    test_contention(3'b111, 6);
    test_reset_mid();
    test_contention(3'b011, 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
